// File: rtl/rca_mp_seq.sv
// Multi-precision add/subtract sequencer: one CHUNK_W-bit ripple-carry adder
// is reused NUM_CHUNKS times, LSB chunk first, with the carry chained through a register.

module rca #(
   parameter int W = 8
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic         carry_i,
   output logic [W-1:0] s_o,
   output logic         carry_o
);

   logic [W:0] c_s;

   assign c_s[0] = carry_i;

   for (genvar i = 0; i < W; i++) begin : g_fa
      assign s_o[i]   = a_i[i] ^ b_i[i] ^ c_s[i];
      assign c_s[i+1] = (a_i[i] & b_i[i]) | (c_s[i] & (a_i[i] ^ b_i[i]));
   end

   assign carry_o = c_s[W];

endmodule

module rca_mp_seq #(
   parameter int CHUNK_W    = 8,
   parameter int NUM_CHUNKS = 4,
   parameter int W          = CHUNK_W * NUM_CHUNKS
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] op_a,
   input  logic [W-1:0] op_b,
   input  logic         carry_in,
   input  logic         sub,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] sum,
   output logic         carry_out,
   output logic         busy
);

   localparam int IDX_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [W-1:0]     a_q, a_d;
   logic [W-1:0]     b_q, b_d;
   logic             cy_q, cy_d;
   logic [W-1:0]     sum_q, sum_d;
   logic             co_q, co_d;
   logic             ov_q, ov_d;
   logic             busy_q, busy_d;
   logic             rdy_q, rdy_d;

   logic [CHUNK_W-1:0] rca_s_s;
   logic               rca_co_s;

   // Operand latches shift right each RUN cycle, so the active chunk is always the low slice.
   rca #(.W(CHUNK_W)) u_rca (
      .a_i     (a_q[CHUNK_W-1:0]),
      .b_i     (b_q[CHUNK_W-1:0]),
      .carry_i (cy_q),
      .s_o     (rca_s_s),
      .carry_o (rca_co_s)
   );

   // Next-state, datapath and registered-output computation.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      cy_d    = cy_q;
      sum_d   = sum_q;
      co_d    = co_q;

      case (state_q)
         IDLE: begin
            if (in_valid && rdy_q) begin
               a_d     = op_a;
               b_d     = sub ? ~op_b : op_b;
               cy_d    = sub ? 1'b1 : carry_in;
               idx_d   = '0;
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            a_d  = a_q >> CHUNK_W;
            b_d  = b_q >> CHUNK_W;
            cy_d = rca_co_s;
            for (int k = 0; k < NUM_CHUNKS; k++) begin
               sum_d[k*CHUNK_W +: CHUNK_W] = (idx_q == IDX_W'(k)) ? rca_s_s
                                                                   : sum_q[k*CHUNK_W +: CHUNK_W];
            end
            if (idx_q == LAST_IDX) begin
               co_d    = rca_co_s;
               idx_d   = '0;
               state_d = DONE;
            end else begin
               idx_d   = idx_q + IDX_W'(1);
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Handshake flags follow the next state so they come straight from flops.
      rdy_d  = (state_d == IDLE);
      ov_d   = (state_d == DONE);
      busy_d = (state_d != IDLE);
   end

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         cy_q    <= 1'b0;
         sum_q   <= '0;
         co_q    <= 1'b0;
         ov_q    <= 1'b0;
         busy_q  <= 1'b0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         cy_q    <= cy_d;
         sum_q   <= sum_d;
         co_q    <= co_d;
         ov_q    <= ov_d;
         busy_q  <= busy_d;
         rdy_q   <= rdy_d;
      end
   end

   assign in_ready  = rdy_q;
   assign out_valid = ov_q;
   assign busy      = busy_q;
   assign sum       = sum_q;
   assign carry_out = co_q;

endmodule

// File: tb/tb_rca_mp_seq.sv
// Directed-vector bench for rca_mp_seq: the driver pushes hand-computed results
// into a scoreboard, a negedge monitor pops and compares on each result handshake.

module tb_rca_mp_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        carry_in;
   logic        sub;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] sum;
   logic        carry_out;
   logic        busy;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_pop = 0;
   logic prev_ov = 1'b0;

   logic [32:0] exp_q[$];
   int          acc_q[$];

   rca_mp_seq #(.CHUNK_W(8), .NUM_CHUNKS(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_a      (op_a),
      .op_b      (op_b),
      .carry_in  (carry_in),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .carry_out (carry_out),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: latency on each out_valid rise, result compare on each handshake.
   always @(negedge clk) begin
      if (rst) begin
         if (in_valid && in_ready) acc_q.push_back(cyc + 1);
         if (out_valid && !prev_ov) begin
            if (acc_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL latency: got out_valid with no accepted request, expected none");
            end else begin
               chk("latency", 64'(cyc - acc_q.pop_front()), 64'd4);
            end
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_result: got sum 0x%0h, expected no result", sum);
            end else begin
               logic [32:0] e;
               e = exp_q.pop_front();
               chk("sum", 64'(sum), 64'(e[31:0]));
               chk("carry_out", 64'(carry_out), 64'(e[32]));
               last_pop = cyc + 1;
            end
         end
      end
      prev_ov = out_valid;
   end

   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic ci,
                        input logic s, input logic [31:0] es, input logic ec,
                        input bit hold_valid, output int acc);
      bit done;
      done = 1'b0;
      acc = -1;
      op_a = a; op_b = b; carry_in = ci; sub = s; in_valid = 1'b1;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         if (in_ready) begin
            exp_q.push_back({ec, es});
            @(posedge clk);
            #1;
            acc = cyc;
            done = 1'b1;
         end
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL accept_timeout: got in_ready=0 for 50 cycles, expected 1");
      end
      if (!hold_valid) in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
      if (exp_q.size() != 0) begin
         checks++; errors++;
         $display("FAIL drain_timeout: got %0d pending results, expected 0", exp_q.size());
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int acc1, acc2;
      rst = 1'b0; in_valid = 1'b0; op_a = 32'h0; op_b = 32'h0;
      carry_in = 1'b0; sub = 1'b0; out_ready = 1'b1;

      #12;
      chk("rst_sum", 64'(sum), 64'h0);
      chk("rst_carry_out", 64'(carry_out), 64'h0);
      chk("rst_out_valid", 64'(out_valid), 64'h0);
      chk("rst_busy", 64'(busy), 64'h0);
      chk("rst_in_ready", 64'(in_ready), 64'h0);
      #6 rst = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_in_ready", 64'(in_ready), 64'h1);

      issue(32'h0000000F, 32'h00000000, 1'b1, 1'b0, 32'h00000010, 1'b0, 1'b0, acc1);
      drain();
      issue(32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0, acc1);
      drain();
      issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, acc1);
      drain();
      issue(32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, acc1);
      drain();
      issue(32'h000000F0, 32'h0000000F, 1'b0, 1'b1, 32'h000000E1, 1'b1, 1'b0, acc1);
      drain();

      // Back-pressure in DONE with a competing request.
      out_ready = 1'b0;
      issue(32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0, acc1);
      for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
      chk("bp_out_valid", 64'(out_valid), 64'h1);
      op_a = 32'hDEADBEEF; op_b = 32'h1; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("bp_sum_stable", 64'(sum), 64'h23456789);
         chk("bp_carry_stable", 64'(carry_out), 64'h0);
         chk("bp_in_ready", 64'(in_ready), 64'h0);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_release_out_valid", 64'(out_valid), 64'h0);
      chk("bp_release_in_ready", 64'(in_ready), 64'h1);
      chk("bp_release_busy", 64'(busy), 64'h0);
      chk("bp_pending", 64'(exp_q.size()), 64'h0);

      // Back-to-back with in_valid held high.
      issue(32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, acc1);
      issue(32'h00010000, 32'h00000001, 1'b0, 1'b1, 32'h0000FFFF, 1'b1, 1'b0, acc2);
      chk("b2b_accept_edge", 64'(acc2), 64'(last_pop + 1));
      drain();

      // Reset in the middle of RUN.
      issue(32'hAAAAAAAA, 32'h55555555, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, acc1);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      #1;
      chk("midrun_rst_sum", 64'(sum), 64'h0);
      chk("midrun_rst_out_valid", 64'(out_valid), 64'h0);
      chk("midrun_rst_busy", 64'(busy), 64'h0);
      exp_q.delete();
      acc_q.delete();
      repeat (2) @(posedge clk);
      #3 rst = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("no_stale_out_valid", 64'(out_valid), 64'h0);
      end
      @(posedge clk); #1;
      issue(32'h0000003C, 32'h00000004, 1'b1, 1'b0, 32'h00000041, 1'b0, 1'b0, acc1);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
